// File: rtl/cube_scan_sequencer_if.sv
// Bus bundle between the scan sequencer, its pattern ROM and the shift-out stage.
// The master side is the sequencer. It drives ROM reads and presents row words.
interface cube_scan_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int ROW_BYTES  = 7
);
  logic                            mem_rd_en;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH*ROW_BYTES-1:0] out_row_data;
  logic [DATA_WIDTH-1:0]           out_plane_sel;
  logic [1:0]                      out_color;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_row_data, out_plane_sel, out_color,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_row_data, out_plane_sel, out_color,
    output mem_data, out_ready
  );
endinterface

// File: rtl/cube_scan_sequencer.sv
// Cube scan sequencer. On each accepted scan tick it reads one plane/colour row set
// from the synchronous pattern ROM and assembles it into one wide word. It then offers
// the word downstream over valid/ready and advances the plane/colour counters on transfer.
module cube_scan_sequencer #(
  parameter int PLANES     = 7,
  parameter int COLORS     = 3,
  parameter int ROW_BYTES  = 7,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  master_clk,
  input  logic                  reset,
  input  logic                  scan_tick,
  input  logic                  enable,
  cube_scan_sequencer_if.master bus,
  output logic                  frame_done,
  output logic                  overrun
);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int IW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

  state_t                                state, state_nxt;
  logic [PW-1:0]                         plane;
  logic [1:0]                            colour;
  logic [IW-1:0]                         byte_idx, cap_idx;
  logic                                  cap_vld;
  logic                                  rd_en_q;
  logic [ADDR_WIDTH-1:0]                 addr_q, base_addr;
  logic [ROW_BYTES-1:0][DATA_WIDTH-1:0]  row_q;
  logic [DATA_WIDTH-1:0]                 plane_sel_q;
  logic [1:0]                            color_q;
  logic                                  start, xfer, last_idx, last_item;

  assign bus.mem_rd_en     = rd_en_q;
  assign bus.mem_addr      = addr_q;
  assign bus.out_valid     = (state == PRESENT);
  assign bus.out_row_data  = row_q;
  assign bus.out_plane_sel = plane_sel_q;
  assign bus.out_color     = color_q;

  assign start     = (state == IDLE) && scan_tick && enable;
  assign xfer      = (state == PRESENT) && bus.out_ready;
  assign last_idx  = (byte_idx == IW'(ROW_BYTES - 1));
  assign last_item = (plane == PW'(PLANES - 1)) && (colour == 2'(COLORS - 1));
  assign base_addr = (ADDR_WIDTH'(plane) * ADDR_WIDTH'(COLORS) + ADDR_WIDTH'(colour))
                     * ADDR_WIDTH'(ROW_BYTES);

  // State register
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: fetch ROW_BYTES addresses, one drain cycle for the ROM latency, then hold until accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)         state_nxt = FETCH;
      FETCH:   if (last_idx)      state_nxt = DRAIN;
      DRAIN:                      state_nxt = PRESENT;
      PRESENT: if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: ROM addressing, byte capture one cycle behind the address, tags, counters, flags
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      byte_idx    <= '0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      row_q       <= '0;
      plane_sel_q <= '0;
      color_q     <= '0;
      plane       <= '0;
      colour      <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // ROM data for the address issued last cycle is on mem_data now
      cap_vld <= rd_en_q;
      cap_idx <= byte_idx;
      if (cap_vld) row_q[cap_idx] <= bus.mem_data;

      if (start) begin
        rd_en_q     <= 1'b1;
        addr_q      <= base_addr;
        byte_idx    <= '0;
        plane_sel_q <= DATA_WIDTH'(1) << plane;
        color_q     <= colour;
      end else if (state == FETCH) begin
        if (last_idx) begin
          rd_en_q <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          addr_q   <= addr_q + 1'b1;
        end
      end

      frame_done <= xfer && last_item;
      if (xfer) begin
        if (colour == 2'(COLORS - 1)) begin
          colour <= '0;
          plane  <= (plane == PW'(PLANES - 1)) ? '0 : plane + 1'b1;
        end else begin
          colour <= colour + 1'b1;
        end
      end

      // Any tick outside IDLE is lost; includes the tick coinciding with the transfer edge
      if (scan_tick && (state != IDLE)) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Bench for cube_scan_sequencer. The ROM model returns addr+1. Expected words and ROM
// addresses are queued when a tick is issued. A negedge monitor pops and compares them
// on every ROM read and every output handshake.
module tb_cube_scan_sequencer;
  logic master_clk = 1'b0;
  logic reset      = 1'b1;
  logic scan_tick  = 1'b0;
  logic enable     = 1'b1;
  logic frame_done, overrun;

  cube_scan_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .ROW_BYTES(7)) bus();

  cube_scan_sequencer dut (
    .master_clk (master_clk),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 master_clk = ~master_clk;

  // Synchronous ROM: data one cycle after the read strobe
  initial bus.mem_data = '0;
  always @(posedge master_clk) if (bus.mem_rd_en) bus.mem_data <= 8'(bus.mem_addr + 9'd1);

  typedef struct packed { logic [55:0] row; logic [7:0] sel; logic [1:0] col; } exp_t;
  exp_t       exp_q[$];
  logic [8:0] addr_q[$];
  int checks = 0, errors = 0, fd_cnt = 0;
  int tp = 0, tc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge master_clk) begin
    if (!reset) begin
      if (bus.mem_rd_en) begin
        if (addr_q.size() == 0) chk("addr_unexpected", 128'(bus.mem_addr), 128'h1ff_dead);
        else chk("mem_addr", 128'(bus.mem_addr), 128'(addr_q.pop_front()));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("word_unexpected", 128'(bus.out_row_data), 128'h1);
        else chk("word", 128'({bus.out_row_data, bus.out_plane_sel, bus.out_color}),
                 128'(exp_q.pop_front()));
      end
      if (frame_done) fd_cnt++;
    end
  end

  function automatic exp_t model_word();
    exp_t e;
    int base;
    base = (tp * 3 + tc) * 7;
    for (int i = 0; i < 7; i++) e.row[i*8 +: 8] = 8'(base + i + 1);
    e.sel = 8'(1 << tp);
    e.col = 2'(tc);
    return e;
  endfunction

  task automatic push_expected();
    int base;
    base = (tp * 3 + tc) * 7;
    exp_q.push_back(model_word());
    for (int i = 0; i < 7; i++) addr_q.push_back(9'(base + i));
  endtask

  task automatic tick();
    @(posedge master_clk); #1 scan_tick = 1'b1;
    @(posedge master_clk); #1 scan_tick = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge master_clk);
      n++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin
      errors++; checks++;
      $display("FAIL wait_valid: got timeout expected out_valid");
    end
  endtask

  task automatic handshake();
    @(posedge master_clk); #1 bus.out_ready = 1'b1;
    @(posedge master_clk); #1 bus.out_ready = 1'b0;
    if (tc == 2) begin tc = 0; tp = (tp == 6) ? 0 : tp + 1; end
    else tc++;
  endtask

  task automatic do_reset();
    @(posedge master_clk); #3 reset = 1'b1;
    #1;
    chk("reset_zero", 128'({bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_row_data,
                            bus.out_plane_sel, bus.out_color, frame_done, overrun}), 128'h0);
    exp_q.delete(); addr_q.delete(); tp = 0; tc = 0;
    @(posedge master_clk); #2 reset = 1'b0;
    @(negedge master_clk);
    chk("post_reset_valid", 128'(bus.out_valid), 128'h0);
  endtask

  initial begin
    int n;
    exp_t e;
    bus.out_ready = 1'b0;
    @(posedge master_clk); #2 reset = 1'b0;

    // 1. reset with a mid-cycle edge
    do_reset();

    // ticks in IDLE with enable low are dropped silently
    enable = 1'b0;
    tick();
    repeat (12) @(negedge master_clk);
    chk("disabled_valid", 128'(bus.out_valid), 128'h0);
    chk("disabled_overrun", 128'(overrun), 128'h0);
    enable = 1'b1;

    // 2. first fetch and latency
    push_expected();
    tick();
    wait_valid(n);
    chk("latency", 128'(n), 128'd9);
    chk("first_row", 128'(bus.out_row_data), 128'h07060504030201);
    chk("first_sel", 128'(bus.out_plane_sel), 128'h01);
    chk("first_col", 128'(bus.out_color), 128'h0);

    // 3. backpressure: word and tags stay put
    for (int i = 0; i < 20; i++) begin
      @(negedge master_clk);
      chk("hold", 128'({bus.out_valid, bus.out_row_data, bus.out_plane_sel, bus.out_color}),
          128'({1'b1, 56'h07060504030201, 8'h01, 2'd0}));
    end
    handshake();
    @(negedge master_clk);
    chk("valid_drop", 128'(bus.out_valid), 128'h0);

    // 4. words 2..21, then the wrap back to plane 0
    for (int k = 2; k <= 21; k++) begin
      push_expected();
      tick();
      wait_valid(n);
      if (k == 21) begin
        chk("w21_sel", 128'(bus.out_plane_sel), 128'h40);
        chk("w21_col", 128'(bus.out_color), 128'h2);
        chk("pre_fd_cnt", 128'(fd_cnt), 128'h0);
      end
      handshake();
      if (k == 21) begin
        @(negedge master_clk);
        chk("frame_done", 128'(frame_done), 128'h1);
      end
    end
    push_expected();
    tick();
    wait_valid(n);
    chk("wrap_sel", 128'(bus.out_plane_sel), 128'h01);
    chk("wrap_col", 128'(bus.out_color), 128'h0);
    handshake();
    @(negedge master_clk);
    chk("fd_once", 128'(fd_cnt), 128'h1);

    // 5. overrun: second tick three cycles into FETCH
    push_expected();
    tick();
    @(posedge master_clk);
    tick();
    @(negedge master_clk);
    chk("overrun_set", 128'(overrun), 128'h1);
    wait_valid(n);
    handshake();
    repeat (3) @(negedge master_clk);
    chk("overrun_sticky", 128'(overrun), 128'h1);
    chk("overrun_idle", 128'(bus.out_valid), 128'h0);
    do_reset();

    // 6. reset while the word is presented
    push_expected();
    push_expected();
    tick();
    wait_valid(n);
    do_reset();
    push_expected();
    e = model_word();
    tick();
    wait_valid(n);
    chk("after_reset_row", 128'(bus.out_row_data), 128'(e.row));
    chk("after_reset_sel", 128'(bus.out_plane_sel), 128'h01);
    handshake();
    repeat (3) @(negedge master_clk);
    chk("queues_empty", 128'(exp_q.size() + addr_q.size()), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
